// File: rtl/decode_stage.sv
// RV32I (+ optional RV32M) instruction-decode stage with a one-entry output
// register, valid/ready handshake, flush and a saturating counter of
// accepted illegal instructions.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_imm_sel,
  output logic [2:0]       out_B_J,
  output logic [4:0]       out_alu_op,
  output logic [1:0]       out_data_size,
  output logic             out_extension_type,
  output logic [1:0]       out_wb_src,
  output logic             out_alu_src,
  output logic             out_op1_src,
  output logic             out_memwrite_en,
  output logic             out_regwrite_en,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate formats
  localparam logic [2:0] IMM_U  = 3'b000;
  localparam logic [2:0] IMM_J  = 3'b001;
  localparam logic [2:0] IMM_S  = 3'b010;
  localparam logic [2:0] IMM_B  = 3'b011;
  localparam logic [2:0] IMM_I  = 3'b100;
  localparam logic [2:0] IMM_SH = 3'b101;
  localparam logic [2:0] IMM_IU = 3'b110;

  // Branch / jump kinds
  localparam logic [2:0] BJ_NONE = 3'b000;
  localparam logic [2:0] BJ_BEQ  = 3'b001;
  localparam logic [2:0] BJ_BNE  = 3'b010;
  localparam logic [2:0] BJ_BLT  = 3'b011;
  localparam logic [2:0] BJ_BGE  = 3'b100;
  localparam logic [2:0] BJ_BLTU = 3'b101;
  localparam logic [2:0] BJ_BGEU = 3'b110;
  localparam logic [2:0] BJ_JUMP = 3'b111;

  // ALU operations
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  localparam logic [1:0] SIZE_NONE = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC4 = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [2:0] b_j;
    logic [4:0] alu_op;
    logic [1:0] data_size;
    logic       ext;
    logic [1:0] wb_src;
    logic       alu_src;
    logic       op1_src;
    logic       memwrite;
    logic       regwrite;
    logic       illegal;
  } ctrl_t;

  // Inert bundle: no writes, no branch, no memory access.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c           = '0;
    c.data_size = SIZE_NONE;
    return c;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      ctrl_d;
  logic       bad;
  logic       accept;

  logic             vld_p1;
  ctrl_t            ctrl_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [31:0]      instr_p1;
  logic [CNT_W-1:0] cnt_p1;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Combinational decode of the incoming instruction into a control bundle.
  always_comb begin
    ctrl_d = ctrl_idle();
    bad    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_d.imm_sel  = IMM_U;
        ctrl_d.wb_src   = WB_IMM;
        ctrl_d.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_d.imm_sel  = IMM_U;
        ctrl_d.op1_src  = 1'b1;
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.wb_src   = WB_ALU;
        ctrl_d.regwrite = 1'b1;
      end
      OPC_JAL: begin
        ctrl_d.imm_sel  = IMM_J;
        ctrl_d.op1_src  = 1'b1;
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.b_j      = BJ_JUMP;
        ctrl_d.wb_src   = WB_PC4;
        ctrl_d.regwrite = 1'b1;
      end
      OPC_JALR: begin
        ctrl_d.imm_sel  = IMM_I;
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.alu_op   = ALU_ADD;
        ctrl_d.b_j      = BJ_JUMP;
        ctrl_d.wb_src   = WB_PC4;
        ctrl_d.regwrite = 1'b1;
        bad             = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_d.imm_sel = IMM_B;
        ctrl_d.op1_src = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
        case (funct3)
          3'b000:  ctrl_d.b_j = BJ_BEQ;
          3'b001:  ctrl_d.b_j = BJ_BNE;
          3'b100:  ctrl_d.b_j = BJ_BLT;
          3'b101:  ctrl_d.b_j = BJ_BGE;
          3'b110:  ctrl_d.b_j = BJ_BLTU;
          3'b111:  ctrl_d.b_j = BJ_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        // funct3[1:0] is the access size, funct3[2] selects zero-extension.
        ctrl_d.imm_sel   = IMM_I;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.data_size = funct3[1:0];
        ctrl_d.ext       = funct3[2];
        ctrl_d.wb_src    = WB_MEM;
        ctrl_d.regwrite  = 1'b1;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl_d.imm_sel   = IMM_S;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.data_size = funct3[1:0];
        ctrl_d.memwrite  = 1'b1;
        bad              = (funct3 >= 3'b011);
      end
      OPC_OPIMM: begin
        ctrl_d.imm_sel  = IMM_I;
        ctrl_d.alu_src  = 1'b1;
        ctrl_d.wb_src   = WB_ALU;
        ctrl_d.regwrite = 1'b1;
        case (funct3)
          3'b000: ctrl_d.alu_op = ALU_ADD;
          3'b010: ctrl_d.alu_op = ALU_SLT;
          3'b011: begin
            ctrl_d.alu_op  = ALU_SLTU;
            ctrl_d.imm_sel = IMM_IU;
          end
          3'b100: ctrl_d.alu_op = ALU_XOR;
          3'b110: ctrl_d.alu_op = ALU_OR;
          3'b111: ctrl_d.alu_op = ALU_AND;
          3'b001: begin
            ctrl_d.alu_op  = ALU_SLL;
            ctrl_d.imm_sel = IMM_SH;
            bad            = (funct7 != F7_BASE);
          end
          default: begin
            ctrl_d.imm_sel = IMM_SH;
            if (funct7 == F7_BASE)     ctrl_d.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) ctrl_d.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        ctrl_d.wb_src   = WB_ALU;
        ctrl_d.regwrite = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  ctrl_d.alu_op = ALU_ADD;
            3'b001:  ctrl_d.alu_op = ALU_SLL;
            3'b010:  ctrl_d.alu_op = ALU_SLT;
            3'b011:  ctrl_d.alu_op = ALU_SLTU;
            3'b100:  ctrl_d.alu_op = ALU_XOR;
            3'b101:  ctrl_d.alu_op = ALU_SRL;
            3'b110:  ctrl_d.alu_op = ALU_OR;
            default: ctrl_d.alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          // Only SUB and SRA exist in the alternate encoding.
          if (funct3 == 3'b000)      ctrl_d.alu_op = ALU_SUB;
          else if (funct3 == 3'b101) ctrl_d.alu_op = ALU_SRA;
          else                       bad = 1'b1;
        end else if (funct7 == F7_MUL && SUPPORT_M) begin
          ctrl_d.alu_op = {2'b10, funct3};
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl_d         = ctrl_idle();
      ctrl_d.illegal = 1'b1;
    end
  end

  // Output register: flush beats accept, accept beats drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= ctrl_idle();
      pc_p1    <= '0;
      instr_p1 <= '0;
      cnt_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      ctrl_p1  <= ctrl_d;
      pc_p1    <= in_pc;
      instr_p1 <= in_instr;
      if (ctrl_d.illegal) cnt_p1 <= sat_inc(cnt_p1);
    end else if (in_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid          = vld_p1;
  assign out_pc             = pc_p1;
  assign out_instr          = instr_p1;
  assign out_rs1            = instr_p1[19:15];
  assign out_rs2            = instr_p1[24:20];
  assign out_rd             = instr_p1[11:7];
  assign out_imm_sel        = ctrl_p1.imm_sel;
  assign out_B_J            = ctrl_p1.b_j;
  assign out_alu_op         = ctrl_p1.alu_op;
  assign out_data_size      = ctrl_p1.data_size;
  assign out_extension_type = ctrl_p1.ext;
  assign out_wb_src         = ctrl_p1.wb_src;
  assign out_alu_src        = ctrl_p1.alu_src;
  assign out_op1_src        = ctrl_p1.op1_src;
  assign out_memwrite_en    = ctrl_p1.memwrite;
  assign out_regwrite_en    = ctrl_p1.regwrite;
  assign out_illegal        = ctrl_p1.illegal;
  assign illegal_cnt        = cnt_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Two instances share all inputs:
// u_a decodes RV32M with an 8-bit counter, u_b rejects RV32M with a 2-bit
// counter so saturation is reachable quickly.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ext, a_alu_src, a_op1_src, a_mw, a_rw, a_ill;
  logic [31:0] a_pc, a_instr;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_alu_op;
  logic [2:0]  a_imm_sel, a_bj;
  logic [1:0]  a_size, a_wb;
  logic [7:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_ext, b_alu_src, b_op1_src, b_mw, b_rw, b_ill;
  logic [31:0] b_pc, b_instr;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_alu_op;
  logic [2:0]  b_imm_sel, b_bj;
  logic [1:0]  b_size, b_wb;
  logic [1:0]  b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SUPPORT_M(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_instr(a_instr),
    .out_imm_sel(a_imm_sel), .out_B_J(a_bj), .out_alu_op(a_alu_op),
    .out_data_size(a_size), .out_extension_type(a_ext), .out_wb_src(a_wb),
    .out_alu_src(a_alu_src), .out_op1_src(a_op1_src),
    .out_memwrite_en(a_mw), .out_regwrite_en(a_rw),
    .out_illegal(a_ill), .illegal_cnt(a_cnt)
  );

  decode_stage #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_instr(b_instr),
    .out_imm_sel(b_imm_sel), .out_B_J(b_bj), .out_alu_op(b_alu_op),
    .out_data_size(b_size), .out_extension_type(b_ext), .out_wb_src(b_wb),
    .out_alu_src(b_alu_src), .out_op1_src(b_op1_src),
    .out_memwrite_en(b_mw), .out_regwrite_en(b_rw),
    .out_illegal(b_ill), .illegal_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();

    chk("rst_valid",    {31'b0, a_out_valid}, 32'd0);
    chk("rst_size",     {30'b0, a_size},      32'd3);
    chk("rst_regwrite", {31'b0, a_rw},        32'd0);
    chk("rst_alu_op",   {27'b0, a_alu_op},    32'd0);
    chk("rst_cnt_a",    {24'b0, a_cnt},       32'd0);
    chk("rst_cnt_b",    {30'b0, b_cnt},       32'd0);
    rst_n = 1'b1;
    tick();

    // ADD x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
    tick();
    chk("add_valid",  {31'b0, a_out_valid}, 32'd1);
    chk("add_alu_op", {27'b0, a_alu_op},    32'd0);
    chk("add_rs1",    {27'b0, a_rs1},       32'd1);
    chk("add_rs2",    {27'b0, a_rs2},       32'd2);
    chk("add_rd",     {27'b0, a_rd},        32'd3);
    chk("add_rw",     {31'b0, a_rw},        32'd1);
    chk("add_wb",     {30'b0, a_wb},        32'd0);
    chk("add_alusrc", {31'b0, a_alu_src},   32'd0);
    chk("add_pc",     a_pc,                 32'h100);
    chk("add_size",   {30'b0, a_size},      32'd3);

    // SUB then LW x5,8(x1), back to back
    in_instr = 32'h402081B3; in_pc = 32'h104;
    tick();
    chk("sub_valid",  {31'b0, a_out_valid}, 32'd1);
    chk("sub_alu_op", {27'b0, a_alu_op},    32'd1);
    in_instr = 32'h0080A283; in_pc = 32'h108;
    tick();
    chk("lw_imm_sel", {29'b0, a_imm_sel},   32'd4);
    chk("lw_size",    {30'b0, a_size},      32'd2);
    chk("lw_wb",      {30'b0, a_wb},        32'd1);
    chk("lw_rd",      {27'b0, a_rd},        32'd5);
    chk("lw_alusrc",  {31'b0, a_alu_src},   32'd1);
    chk("lw_ext",     {31'b0, a_ext},       32'd0);
    chk("lw_instr",   a_instr,              32'h0080A283);

    // MUL x3,x1,x2: legal with M, illegal without
    in_instr = 32'h022081B3; in_pc = 32'h10C;
    tick();
    chk("mul_a_alu_op", {27'b0, a_alu_op}, 32'h10);
    chk("mul_a_ill",    {31'b0, a_ill},    32'd0);
    chk("mul_a_rw",     {31'b0, a_rw},     32'd1);
    chk("mul_a_cnt",    {24'b0, a_cnt},    32'd0);
    chk("mul_b_ill",    {31'b0, b_ill},    32'd1);
    chk("mul_b_rw",     {31'b0, b_rw},     32'd0);
    chk("mul_b_size",   {30'b0, b_size},   32'd3);
    chk("mul_b_bj",     {29'b0, b_bj},     32'd0);
    chk("mul_b_cnt",    {30'b0, b_cnt},    32'd1);

    // Back-pressure for 3 cycles with ADDI x1,x0,12 waiting
    out_ready = 1'b0; in_instr = 32'h00C00093; in_pc = 32'h110;
    #1;
    chk("stall_in_ready", {31'b0, a_in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid",  {31'b0, a_out_valid}, 32'd1);
      chk("stall_alu_op", {27'b0, a_alu_op},    32'h10);
      chk("stall_rd",     {27'b0, a_rd},        32'd3);
      chk("stall_pc",     a_pc,                 32'h10C);
      chk("stall_b_cnt",  {30'b0, b_cnt},       32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, a_in_ready}, 32'd1);
    tick();
    chk("addi_rd",      {27'b0, a_rd},      32'd1);
    chk("addi_alu_op",  {27'b0, a_alu_op},  32'd0);
    chk("addi_alusrc",  {31'b0, a_alu_src}, 32'd1);
    chk("addi_imm_sel", {29'b0, a_imm_sel}, 32'd4);
    chk("addi_pc",      a_pc,               32'h110);

    // BNE x1,x2,+8
    in_instr = 32'h00209463; in_pc = 32'h114;
    tick();
    chk("bne_bj",      {29'b0, a_bj},      32'd2);
    chk("bne_imm_sel", {29'b0, a_imm_sel}, 32'd3);
    chk("bne_op1",     {31'b0, a_op1_src}, 32'd1);
    chk("bne_rw",      {31'b0, a_rw},      32'd0);
    chk("bne_size",    {30'b0, a_size},    32'd3);

    // SRAI x1,x1,3
    in_instr = 32'h4030D093; in_pc = 32'h118;
    tick();
    chk("srai_alu_op",  {27'b0, a_alu_op},  32'd7);
    chk("srai_imm_sel", {29'b0, a_imm_sel}, 32'd5);
    chk("srai_ill",     {31'b0, a_ill},     32'd0);

    // SW x2,4(x1)
    in_instr = 32'h0020A223; in_pc = 32'h11C;
    tick();
    chk("sw_mw",      {31'b0, a_mw},      32'd1);
    chk("sw_size",    {30'b0, a_size},    32'd2);
    chk("sw_imm_sel", {29'b0, a_imm_sel}, 32'd2);
    chk("sw_rw",      {31'b0, a_rw},      32'd0);

    // JAL x1,0
    in_instr = 32'h000000EF; in_pc = 32'h120;
    tick();
    chk("jal_bj",      {29'b0, a_bj},      32'd7);
    chk("jal_wb",      {30'b0, a_wb},      32'd3);
    chk("jal_imm_sel", {29'b0, a_imm_sel}, 32'd1);
    chk("jal_op1",     {31'b0, a_op1_src}, 32'd1);

    // Flush with an illegal word on the input
    flush = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h124;
    tick();
    chk("flush_valid_a", {31'b0, a_out_valid}, 32'd0);
    chk("flush_valid_b", {31'b0, b_out_valid}, 32'd0);
    chk("flush_cnt_a",   {24'b0, a_cnt},       32'd0);
    chk("flush_cnt_b",   {30'b0, b_cnt},       32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_valid", {31'b0, a_out_valid}, 32'd0);

    // Illegal opcode stream, then reset mid-stream
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h200;
    tick();
    chk("ill1_cnt_b", {30'b0, b_cnt}, 32'd2);
    chk("ill1_ill_a", {31'b0, a_ill}, 32'd1);
    tick();
    chk("ill2_cnt_b", {30'b0, b_cnt}, 32'd3);
    chk("ill2_cnt_a", {24'b0, a_cnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("midrst_cnt_a", {24'b0, a_cnt},       32'd0);
    chk("midrst_cnt_b", {30'b0, b_cnt},       32'd0);
    chk("midrst_size",  {30'b0, a_size},      32'd3);
    chk("midrst_ill",   {31'b0, a_ill},       32'd0);
    #1;
    rst_n = 1'b1;

    // Five illegal accepts: 2-bit counter saturates at 3
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_cnt_b", {30'b0, b_cnt},       (i < 3) ? i : 3);
      chk("sat_cnt_a", {24'b0, a_cnt},       i);
      chk("sat_valid", {31'b0, b_out_valid}, 32'd1);
      chk("sat_ill",   {31'b0, b_ill},       32'd1);
      chk("sat_rw",    {31'b0, b_rw},        32'd0);
    end

    // Drain
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, a_out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
